// File: rtl/bf16_operand_feeder.sv
// rtl/bf16_operand_feeder.sv - packs bf16 operand pairs into N-lane vectors and queues them for the MAC array
// Optional feature macro: FEEDER_ZERO_PAD_EN (short final vectors are zero-padded instead of flagging err)
module bf16_operand_feeder #(
   parameter int N     = 2,
   parameter int DEPTH = 2
) (
   input  logic            clk1,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_a,
   input  logic [15:0]     in_b,
   input  logic            in_last,
   output logic [16*N-1:0] a1,
   output logic [16*N-1:0] b1,
   output logic            cntl1,
   output logic            vec_valid,
   input  logic            vec_ready,
   output logic            vec_last,
   output logic            err
);

`ifdef FEEDER_ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
   logic [16*N-1:0] asm_a_q, asm_b_q;
   logic [16*N-1:0] vec_a_d, vec_b_d;
   logic            first_q, first_d;
   logic            err_q, err_d;

   logic [16*N-1:0] mem_a_q     [DEPTH];
   logic [16*N-1:0] mem_b_q     [DEPTH];
   logic            mem_first_q [DEPTH];
   logic            mem_last_q  [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;

   logic fifo_full, fifo_empty;
   logic accept, at_end, push, pop;

   assign fifo_full  = (count_q == (PW+1)'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign in_ready   = !fifo_full;
   assign accept     = in_valid && in_ready;
   assign at_end     = (lane_cnt_q == LW'(N-1));
   assign push       = accept && (at_end || (ZERO_PAD && in_last));
   assign pop        = !fifo_empty && vec_ready;

   // Completed vector: held lanes, the incoming pair at lane_cnt, and zeros above it when padding.
   always_comb begin
      vec_a_d = asm_a_q;
      vec_b_d = asm_b_q;
      for (int i = 0; i < N; i++) begin
         if (i == int'(lane_cnt_q)) begin
            vec_a_d[16*i +: 16] = in_a;
            vec_b_d[16*i +: 16] = in_b;
         end else if (ZERO_PAD && (i > int'(lane_cnt_q))) begin
            vec_a_d[16*i +: 16] = 16'h0000;
            vec_b_d[16*i +: 16] = 16'h0000;
         end
      end
   end

   always_comb begin
      lane_cnt_d = lane_cnt_q;
      if (accept) begin
         lane_cnt_d = push ? '0 : lane_cnt_q + LW'(1);
      end
      first_d = push ? in_last : first_q;
      err_d   = err_q | (!ZERO_PAD && accept && in_last && !at_end);
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt_q <= '0;
         asm_a_q    <= '0;
         asm_b_q    <= '0;
         first_q    <= 1'b1;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         if (accept) begin
            asm_a_q <= vec_a_d;
            asm_b_q <= vec_b_d;
         end
         first_q  <= first_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never observed while empty, so it needs no reset.
   always_ff @(posedge clk1) begin
      if (push) begin
         mem_a_q[wr_ptr_q]     <= vec_a_d;
         mem_b_q[wr_ptr_q]     <= vec_b_d;
         mem_first_q[wr_ptr_q] <= first_q;
         mem_last_q[wr_ptr_q]  <= in_last;
      end
   end

   assign vec_valid = !fifo_empty;
   assign a1        = fifo_empty ? '0 : mem_a_q[rd_ptr_q];
   assign b1        = fifo_empty ? '0 : mem_b_q[rd_ptr_q];
   assign cntl1     = !fifo_empty && !mem_first_q[rd_ptr_q];
   assign vec_last  = !fifo_empty && mem_last_q[rd_ptr_q];
   assign err       = err_q;

endmodule
